skut_frame_former_p: RTL
========================

Name: skut_frame_former_p

Overview:
Parametrised next-generation SKUT telemetry frame former. On each synchronised frame strobe (8 kHz) it writes one byte per channel into the frame buffer RAM, using an interleaved address map. Channel content is generated internally: middle-level constants, a stepped sine test signal, a 12.5 Hz LKF marker and, optionally, packed discrete inputs. After each frame it issues a single-address DDC fetch. Independently, it generates a DDC burst request on each 100 Hz strobe.

Parameters:
- CHANNELS, 80: channels per frame; must be even; address half = CHANNELS/2.
- ADDR_W, 7: oAddr / oDDCAddr width; 2^ADDR_W >= CHANNELS.
- SLOT_CYCLES, 16: clocks per channel slot; must be >= WR_PULSE+2.
- WR_PULSE, 8: oWrEn high length per slot, in clocks.
- MIDDLE, 124: byte written to middle channels.
- MID_MASK, bits {38,39,78,79} set: CHANNELS-bit mask of middle channels.
- SIN_MASK, bits {29,69} set: CHANNELS-bit mask of sine channels.
- SIN_L0/L1/L2/L3, 28/92/156/220: sine levels; 8-step table L0,L1,L2,L3,L3,L2,L1,L0.
- MARK_CH, 18: LKF marker channel.
- MARK_VAL, 220: marker byte.
- LKF_PERIOD, 640: frames per marker period.
- DDC_COUNT, 80: DDC address range 0..DDC_COUNT-1.
- BURST_LEN, 509: oDDCBReq high length, in clocks.
- DISC_W, 16: iDisc width (even).
- DISC_CH0, 1: first discrete channel.
- DISC_STEP, 2: channel spacing between discrete pairs.

Ports:
- iClk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- i8KHz  in  1  frame strobe, asynchronous
- i100Hz  in  1  DDC burst strobe, asynchronous
- iDisc  in  DISC_W  discrete inputs (used only with DISCRETE_EN)
- oData  out  8  buffer write data
- oAddr  out  ADDR_W  buffer write address
- oWrEn  out  1  buffer write enable
- o19ch  out  1  high during the marker frame's marker slot onward; cleared at the marker slot of the next frame
- oDDCAddr  out  ADDR_W  DDC fetch address
- oDDCReq  out  1  one-clock DDC fetch pulse
- oDDCBReq  out  1  DDC burst request
- oOvr  out  1  one-clock pulse: frame strobe edge lost because the former was busy
- oTest  out  1  high during slot cycle 0 only

Behaviour:
- Synchronisers: both strobes pass through 2 FFs. Rising edge is taken from the synchronised value vs. its delayed copy.
- Reset (reset==0 at posedge): all outputs 0; state IDLE; chan, slot, sin, lkf and ddc_ptr counters = 0; burst FSM idle.
- Frame FSM states: IDLE -> SNAP -> SLOT -> DDC -> IDLE.
- IDLE: on i8KHz rising edge go to SNAP. The edge is detected 3 clocks after the pin edge.
- SNAP (1 clock): latch iDisc into disc_q; chan=0; slot=0.
- SLOT:
  - slot cycle 0: oData/oAddr load, oTest=1.
  - slot cycles 1..WR_PULSE: oWrEn=1.
  - remaining cycles: oWrEn=0.
  - At slot==SLOT_CYCLES-1: if chan==CHANNELS-1 go to DDC, else chan++.
- Address map: chan<CHANNELS/2 -> 2*chan; else 2*(chan-CHANNELS/2)+1. Width ADDR_W, no overflow by parameter constraint.
- Data priority per channel:
  1. MARK_CH: MARK_VAL if lkf==0, else 0. o19ch takes the same condition.
  2. MID_MASK: MIDDLE.
  3. SIN_MASK: table[sin].
  4. Discrete channel (DISCRETE_EN only): see Optional Feature.
  5. Otherwise 0.
- DDC (3 clocks):
  - cycle 0: oDDCAddr=ddc_ptr.
  - cycle 1: oDDCReq=1; ddc_ptr wraps DDC_COUNT-1 -> 0, else increments.
  - cycle 2: sin=(sin+1) mod 8; lkf wraps LKF_PERIOD-1 -> 0, else increments; go to IDLE.
- Frame length: 1 + CHANNELS*SLOT_CYCLES + 3 clocks.
- A frame strobe edge outside IDLE is dropped and pulses oOvr; the frame in progress completes unchanged.
- Burst FSM (independent of the frame FSM):
  - On i100Hz rising edge, oDDCBReq=1 for exactly BURST_LEN clocks.
  - A further edge during the burst is ignored; no retrigger.
  - Simultaneous frame and burst activity is allowed.
- Reset asserted mid-frame or mid-burst: outputs 0 on the next clock; the partial frame is abandoned and no DDC request is issued.

Optional Feature:
- Macro DISCRETE_EN.
- Defined: discrete pair k (0..DISC_W/2-1) drives channel DISC_CH0+k*DISC_STEP with data {disc_q[2k+1:2k], 6'b011100}. Priority is below marker, middle and sine.
- Not defined: iDisc is unused, disc_q is not built, and those channels carry 0.

Decomposition:
- Package skut_pkg:
  - frame FSM state enum;
  - sine table function built from SIN_L0..3;
  - address-map function;
  - constant 6'b011100 (DISC_PAD).
- Sub-module skut_strobe_sync: 2-FF synchroniser plus rising-edge detect. It is instantiated twice (i8KHz, i100Hz).

Test Plan:
- Reset released, one i8KHz pulse -> 80 write bursts of 8 clocks each. Channel 38 gives oAddr=76, oData=124; channel 40 gives oAddr=1. Then oDDCAddr=0 with an oDDCReq pulse.
- 9 consecutive frames -> channel 29 data is 28,92,156,220,220,156,92,28, then 28 again. ddc_ptr goes 0..8.
- 641 frames -> channel 18 is 220 with o19ch=1 in frames 0 and 640, otherwise 0; o19ch=0 between.
- i8KHz edge injected mid-frame -> oOvr pulse, and the frame completes with 80 writes. 80 frames -> oDDCAddr wraps 79 -> 0.
- i100Hz pulse, then a second pulse 100 clocks later -> oDDCBReq high exactly 509 clocks with no extension. Reset asserted mid-burst -> low next clock.
- DISCRETE_EN, iDisc=16'hA5C3 -> channel 1 = 8'hDC (bits 11), channel 3 = 8'h1C (bits 00), channel 15 = 8'h9C (bits 10).

Source files
------------

// File: rtl/skut_pkg.sv
// -----------------------------------------------------------------------------
// skut_pkg
// Shared types and helpers for the SKUT frame former.
//   frame_state_e : frame FSM states (idle, snapshot, channel slots, DDC fetch)
//   DISC_PAD      : low six bits appended to each packed discrete pair
//   sin_level()   : 8-step stepped-sine table L0,L1,L2,L3,L3,L2,L1,L0
//   addr_map()    : interleaved buffer address (first half even, second odd)
// -----------------------------------------------------------------------------
package skut_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSnap,
        StSlot,
        StDdc
    } frame_state_e;

    localparam logic [5:0] DISC_PAD = 6'b011100;

    function automatic logic [7:0] sin_level(input logic [2:0] idx,
                                             input logic [7:0] l0,
                                             input logic [7:0] l1,
                                             input logic [7:0] l2,
                                             input logic [7:0] l3);
        logic [7:0] lvl;
        unique case (idx)
            3'd0, 3'd7: lvl = l0;
            3'd1, 3'd6: lvl = l1;
            3'd2, 3'd5: lvl = l2;
            default:    lvl = l3;
        endcase
        return lvl;
    endfunction

    function automatic int unsigned addr_map(input int unsigned chan,
                                             input int unsigned half);
        if (chan < half) begin
            return 2 * chan;
        end
        return 2 * (chan - half) + 1;
    endfunction

endpackage

// File: rtl/skut_strobe_sync.sv
// -----------------------------------------------------------------------------
// skut_strobe_sync
// Two-flop synchroniser for an asynchronous strobe plus rising-edge detect.
//   i_clk    : system clock
//   i_rst_n  : synchronous active-low reset
//   i_strobe : asynchronous strobe input
//   o_rise   : one-clock pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module skut_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_strobe,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_strobe;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_dly;

endmodule

// File: rtl/skut_frame_former_p.sv
// -----------------------------------------------------------------------------
// skut_frame_former_p
// SKUT telemetry frame former. Each 8 kHz strobe writes one byte per channel
// into the frame buffer (interleaved addresses), then issues one DDC fetch.
// Each 100 Hz strobe raises a fixed-length DDC burst request.
// Optional feature macro: DISCRETE_EN (packs iDisc pairs into channels).
// Ports:
//   iClk, reset      : clock, synchronous active-low reset
//   i8KHz, i100Hz    : asynchronous frame / burst strobes
//   iDisc            : discrete inputs (DISCRETE_EN only)
//   oData,oAddr,oWrEn: buffer write port
//   o19ch            : LKF marker flag
//   oDDCAddr,oDDCReq : single DDC fetch
//   oDDCBReq         : DDC burst request
//   oOvr             : frame strobe dropped while busy
//   oTest            : slot cycle 0 marker
// -----------------------------------------------------------------------------
module skut_frame_former_p
    import skut_pkg::*;
#(
    parameter int unsigned          CHANNELS    = 80,
    parameter int unsigned          ADDR_W      = 7,
    parameter int unsigned          SLOT_CYCLES = 16,
    parameter int unsigned          WR_PULSE    = 8,
    parameter logic [7:0]           MIDDLE      = 8'd124,
    parameter logic [CHANNELS-1:0]  MID_MASK    = (CHANNELS'(1) << 38) | (CHANNELS'(1) << 39) |
                                                  (CHANNELS'(1) << 78) | (CHANNELS'(1) << 79),
    parameter logic [CHANNELS-1:0]  SIN_MASK    = (CHANNELS'(1) << 29) | (CHANNELS'(1) << 69),
    parameter logic [7:0]           SIN_L0      = 8'd28,
    parameter logic [7:0]           SIN_L1      = 8'd92,
    parameter logic [7:0]           SIN_L2      = 8'd156,
    parameter logic [7:0]           SIN_L3      = 8'd220,
    parameter int unsigned          MARK_CH     = 18,
    parameter logic [7:0]           MARK_VAL    = 8'd220,
    parameter int unsigned          LKF_PERIOD  = 640,
    parameter int unsigned          DDC_COUNT   = 80,
    parameter int unsigned          BURST_LEN   = 509,
    parameter int unsigned          DISC_W      = 16,
    parameter int unsigned          DISC_CH0    = 1,
    parameter int unsigned          DISC_STEP   = 2
) (
    input  logic              iClk,
    input  logic              reset,
    input  logic              i8KHz,
    input  logic              i100Hz,
    input  logic [DISC_W-1:0] iDisc,
    output logic [7:0]        oData,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oWrEn,
    output logic              o19ch,
    output logic [ADDR_W-1:0] oDDCAddr,
    output logic              oDDCReq,
    output logic              oDDCBReq,
    output logic              oOvr,
    output logic              oTest
);

    localparam int unsigned ChW = $clog2(CHANNELS);
    localparam int unsigned SlW = $clog2(SLOT_CYCLES);
    localparam int unsigned LkW = $clog2(LKF_PERIOD);
    localparam int unsigned BlW = $clog2(BURST_LEN);

    logic w_frame_rise;
    logic w_burst_rise;

    frame_state_e      r_state;
    frame_state_e      w_state_d;
    logic [ChW-1:0]    r_chan;
    logic [SlW-1:0]    r_slot;
    logic [1:0]        r_ddc_cyc;
    logic [2:0]        r_sin;
    logic [LkW-1:0]    r_lkf;
    logic [ADDR_W-1:0] r_ddc_ptr;
    logic [7:0]        r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_19ch;
    logic [ADDR_W-1:0] r_ddc_addr;
    logic              r_burst;
    logic [BlW-1:0]    r_bcnt;

    logic [7:0]        w_data;
    logic [ADDR_W-1:0] w_addr;
    logic              w_mark;
    logic              w_slot_last;
    logic              w_chan_last;

    skut_strobe_sync u_sync_frame (
        .i_clk    (iClk),
        .i_rst_n  (reset),
        .i_strobe (i8KHz),
        .o_rise   (w_frame_rise)
    );

    skut_strobe_sync u_sync_burst (
        .i_clk    (iClk),
        .i_rst_n  (reset),
        .i_strobe (i100Hz),
        .o_rise   (w_burst_rise)
    );

`ifdef DISCRETE_EN
    logic [DISC_W-1:0] r_disc;

    always_ff @(posedge iClk) begin
        if (!reset) begin
            r_disc <= '0;
        end else if (r_state == StSnap) begin
            r_disc <= iDisc;
        end
    end
`else
    logic w_unused_disc;
    assign w_unused_disc = ^{iDisc, DISC_CH0[0], DISC_STEP[0]};
`endif

    assign w_slot_last = (r_slot == SlW'(SLOT_CYCLES - 1));
    assign w_chan_last = (r_chan == ChW'(CHANNELS - 1));
    assign w_addr      = ADDR_W'(addr_map(32'(r_chan), CHANNELS / 2));

    // Channel content, highest priority first.
    always_comb begin
        w_data = 8'h00;
        w_mark = 1'b0;
        if (32'(r_chan) == MARK_CH) begin
            w_mark = (r_lkf == '0);
            w_data = w_mark ? MARK_VAL : 8'h00;
        end else if (MID_MASK[r_chan]) begin
            w_data = MIDDLE;
        end else if (SIN_MASK[r_chan]) begin
            w_data = sin_level(r_sin, SIN_L0, SIN_L1, SIN_L2, SIN_L3);
        end
`ifdef DISCRETE_EN
        else begin
            for (int unsigned k = 0; k < DISC_W / 2; k++) begin
                if (32'(r_chan) == DISC_CH0 + k * DISC_STEP) begin
                    w_data = {r_disc[2*k+1 -: 2], DISC_PAD};
                end
            end
        end
`endif
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_frame_rise) w_state_d = StSnap;
            StSnap:  w_state_d = StSlot;
            StSlot:  if (w_slot_last && w_chan_last) w_state_d = StDdc;
            StDdc:   if (r_ddc_cyc == 2'd2) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_chan     <= '0;
            r_slot     <= '0;
            r_ddc_cyc  <= '0;
            r_sin      <= '0;
            r_lkf      <= '0;
            r_ddc_ptr  <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_19ch     <= 1'b0;
            r_ddc_addr <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StSnap: begin
                    r_chan <= '0;
                    r_slot <= '0;
                end
                StSlot: begin
                    // Data/address register here so they are stable for the whole strobe.
                    if (r_slot == '0) begin
                        r_data <= w_data;
                        r_addr <= w_addr;
                        if (32'(r_chan) == MARK_CH) r_19ch <= w_mark;
                    end
                    if (w_slot_last) begin
                        r_slot <= '0;
                        if (!w_chan_last) r_chan <= r_chan + 1'b1;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                StDdc: begin
                    r_ddc_cyc <= (r_ddc_cyc == 2'd2) ? 2'd0 : r_ddc_cyc + 2'd1;
                    case (r_ddc_cyc)
                        2'd0: r_ddc_addr <= r_ddc_ptr;
                        2'd1: r_ddc_ptr  <= (r_ddc_ptr == ADDR_W'(DDC_COUNT - 1)) ? '0
                                                                                 : r_ddc_ptr + 1'b1;
                        2'd2: begin
                            r_sin <= r_sin + 3'd1;
                            r_lkf <= (r_lkf == LkW'(LKF_PERIOD - 1)) ? '0 : r_lkf + 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Burst request: no retrigger while active.
    always_ff @(posedge iClk) begin
        if (!reset) begin
            r_burst <= 1'b0;
            r_bcnt  <= '0;
        end else if (r_burst) begin
            if (r_bcnt == BlW'(BURST_LEN - 1)) begin
                r_burst <= 1'b0;
                r_bcnt  <= '0;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end else if (w_burst_rise) begin
            r_burst <= 1'b1;
            r_bcnt  <= '0;
        end
    end

    assign oData    = r_data;
    assign oAddr    = r_addr;
    assign o19ch    = r_19ch;
    assign oDDCAddr = r_ddc_addr;
    assign oDDCBReq = r_burst;
    assign oTest    = (r_state == StSlot) && (r_slot == '0);
    assign oWrEn    = (r_state == StSlot) && (r_slot != '0) && (32'(r_slot) <= WR_PULSE);
    assign oDDCReq  = (r_state == StDdc) && (r_ddc_cyc == 2'd1);
    assign oOvr     = w_frame_rise && (r_state != StIdle);

endmodule
